// File: rtl/placement_out_fifo_if.sv
// rtl/placement_out_fifo_if.sv - placement result input and output stream handshake bundle
interface placement_out_fifo_if;
    logic        in_valid;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [3:0]  strike_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;

    modport master (
        output in_valid, x_in, y_in, strike_in, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, x_in, y_in, strike_in, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/placement_out_fifo.sv
// rtl/placement_out_fifo.sv - registered-output placement FIFO with overflow tracking
// Optional strike filter enabled by defining STRIKE_FILTER_EN.
module placement_out_fifo #(
    parameter int         DEPTH      = 8,
    parameter int         CNT_W      = 8,
    parameter logic [3:0] STRIKE_MAX = 4'd15
) (
    input  logic                     clk,
    input  logic                     rst,
    placement_out_fifo_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_stat
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef STRIKE_FILTER_EN
    localparam bit STRIKE_FILTER = 1'b1;
`else
    localparam bit STRIKE_FILTER = 1'b0;
`endif

    logic [19:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr_inc;
    logic [19:0]    in_word;
    logic           accept;
    logic           push;
    logic           pop;
    logic           drop;
    logic [LW-1:0]  level_nxt;
    logic [19:0]    head_nxt;

    always_comb begin
        in_word    = {bus.strike_in, bus.y_in, bus.x_in};
        accept     = bus.in_valid && !(STRIKE_FILTER && (bus.strike_in >= STRIKE_MAX));
        pop        = bus.out_valid && bus.out_ready;
        push       = accept && (!full || pop);
        drop       = accept && full && !pop;
        rd_ptr_inc = rd_ptr + 1'b1;

        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end

        // out_data mirrors mem[rd_ptr]; an entry written this cycle is taken
        // straight from the input so the head never waits on the array write.
        head_nxt = bus.out_data;
        if (pop) begin
            if (level > LW'(1)) begin
                head_nxt = mem[rd_ptr_inc];
            end else if (push) begin
                head_nxt = in_word;
            end
        end else if ((level == '0) && push) begin
            head_nxt = in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            level         <= '0;
            full          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            level         <= level_nxt;
            full          <= (level_nxt == LW'(DEPTH));
            bus.out_valid <= (level_nxt != '0);
            bus.out_data  <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stat) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_placement_out_fifo.sv
// tb/tb_placement_out_fifo.sv - directed self-checking bench for placement_out_fifo
module tb_placement_out_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       clr_stat;
    logic [3:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;
    int         checks = 0;
    int         errors = 0;

    placement_out_fifo_if bus();

    placement_out_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_stat (clr_stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [3:0] s);
        bus.in_valid  = v;
        bus.x_in      = x;
        bus.y_in      = y;
        bus.strike_in = s;
    endtask

    function automatic logic [19:0] entry(input int i);
        logic [7:0] xi;
        xi = 8'(i);
        return {4'h1, 8'h40 + xi, xi};
    endfunction

    initial begin
        rst = 1'b1;
        clr_stat = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // single result, latency 1
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h12, 8'h34, 4'h3);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("lat1_valid", 32'(bus.out_valid), 32'd1);
        chk("lat1_data", 32'(bus.out_data), 32'h33412);
        chk("lat1_level", 32'(level), 32'd1);
        tick();
        chk("lat1_gone_valid", 32'(bus.out_valid), 32'd0);
        chk("lat1_gone_level", 32'(level), 32'd0);

        // fill to full with consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 8'h40 + 8'(i), 4'h1);
            tick();
            chk("fill_level", 32'(level), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head", 32'(bus.out_data), 32'(entry(0)));

        // three drops, then clear in the same cycle as a fourth drop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 8'h00, 4'h2);
            tick();
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(drop_cnt), 32'd3);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_head", 32'(bus.out_data), 32'(entry(0)));
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_head", 32'(bus.out_data), 32'(entry(0)));

        // push and pop together while full, then drain back-to-back
        drive(1'b1, 8'h88, 8'h88, 4'h2);
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_drop", 32'(drop_cnt), 32'd0);
        chk("pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), (i < 8) ? 32'(entry(i)) : 32'h28888);
            tick();
            chk("drain_level", 32'(level), 32'(8 - i));
        end
        chk("drain_end_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_end_full", 32'(full), 32'd0);

        // empty with ready high stays idle
        tick();
        chk("empty_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_level", 32'(level), 32'd0);

        // reset with entries stored
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 8'h00, 4'h1);
            tick();
        end
        chk("pre_rst_level", 32'(level), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        drive(1'b1, 8'h5A, 8'hA5, 4'h7);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("post_rst_data", 32'(bus.out_data), 32'h7A55A);
        tick();
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'h7A55A);
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_level", 32'(level), 32'd0);

        // strike filter
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 8'h00, 4'hF);
        tick();
        drive(1'b1, 8'h02, 8'h00, 4'h2);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("filt_drop", 32'(drop_cnt), 32'd0);
`ifdef STRIKE_FILTER_EN
        chk("filt_level", 32'(level), 32'd1);
        chk("filt_data", 32'(bus.out_data), 32'h20002);
`else
        chk("filt_level", 32'(level), 32'd2);
        chk("filt_data0", 32'(bus.out_data), 32'hF0001);
        bus.out_ready = 1'b1;
        tick();
        chk("filt_data1", 32'(bus.out_data), 32'h20002);
`endif
        bus.out_ready = 1'b1;
        tick();
        chk("filt_empty", 32'(level), 32'd0);

        // drop counter saturation
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 8'h40 + 8'(i), 4'h1);
            tick();
        end
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'hEE, 8'hEE, 4'h1);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        chk("sat_cnt", 32'(drop_cnt), 32'hFF);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_head", 32'(bus.out_data), 32'(entry(0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
